// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and the divider's state encoding.
package cpu_pkg;

   localparam int CPU_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/sub_borrow.sv
// N-bit subtractor built as A + ~B + 1; a missing carry out signals a borrow (A < B).
module sub_borrow #(
   parameter int N = 9
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_borrow
);

   logic [N:0] w_sum;

   assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};
   assign o_diff   = w_sum[N-1:0];
   assign o_borrow = ~w_sum[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock via trial subtraction,
// with a Start/Busy/Done handshake and registered result outputs.
module seq_divider
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DivZero
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_t         r_state;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisor;
   logic [CNT_W-1:0]   r_cnt;

   logic [2*WIDTH:0]   w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_borrow;
   logic [WIDTH:0]     w_rem_next;
   logic [WIDTH-1:0]   w_quo_next;

   assign w_shift = {r_rem, r_quo} << 1;

   sub_borrow #(.N(WIDTH + 1)) u_sub (
      .i_a      (w_shift[2*WIDTH:WIDTH]),
      .i_b      ({1'b0, r_divisor}),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // Restore on borrow: keep the shifted remainder and shift in a 0 quotient bit.
   assign w_rem_next = w_borrow ? w_shift[2*WIDTH:WIDTH] : w_diff;
   assign w_quo_next = w_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_borrow};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Q         <= '0;
         R         <= '0;
         DivZero   <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (r_state)
            IDLE: begin
               // The Done cycle still reads as IDLE; a Start there is not accepted.
               if (Start && !Done) begin
                  r_divisor <= Divisor;
                  r_rem     <= '0;
                  r_quo     <= Dividend;
                  r_cnt     <= '0;
                  Busy      <= 1'b1;
                  if (Divisor == '0) begin
                     r_state <= FIN;
                     Q       <= '1;
                     R       <= Dividend;
                     DivZero <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= FIN;
                  Q       <= w_quo_next;
                  R       <= w_rem_next[WIDTH-1:0];
                  DivZero <= 1'b0;
               end
            end
            FIN: begin
               r_state <= IDLE;
               Busy    <= 1'b0;
               Done    <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
